// File: rtl/lsu_arbiter_if.sv
// Bus bundle between two LSU requesters, the arbiter and the shared LSU.
// Signal names follow the arbiter's view: i_* flow into it, o_* flow out of it.
interface lsu_arbiter_if;
  logic        i_req0_valid;
  logic        o_req0_ready;
  logic [31:0] i_req0_addr;
  logic [31:0] i_req0_wdata;
  logic [2:0]  i_req0_funct3;
  logic        i_req0_wren;
  logic        o_rsp0_valid;
  logic [31:0] o_rsp0_rdata;

  logic        i_req1_valid;
  logic        o_req1_ready;
  logic [31:0] i_req1_addr;
  logic [31:0] i_req1_wdata;
  logic [2:0]  i_req1_funct3;
  logic        i_req1_wren;
  logic        o_rsp1_valid;
  logic [31:0] o_rsp1_rdata;

  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic [2:0]  o_funct3;
  logic        o_lsu_wren;
  logic [31:0] i_ld_data;

  // Arbiter side
  modport slave (
    input  i_req0_valid, i_req0_addr, i_req0_wdata, i_req0_funct3, i_req0_wren,
    input  i_req1_valid, i_req1_addr, i_req1_wdata, i_req1_funct3, i_req1_wren,
    input  i_ld_data,
    output o_req0_ready, o_rsp0_valid, o_rsp0_rdata,
    output o_req1_ready, o_rsp1_valid, o_rsp1_rdata,
    output o_lsu_addr, o_st_data, o_funct3, o_lsu_wren
  );

  // Requester / LSU side
  modport master (
    output i_req0_valid, i_req0_addr, i_req0_wdata, i_req0_funct3, i_req0_wren,
    output i_req1_valid, i_req1_addr, i_req1_wdata, i_req1_funct3, i_req1_wren,
    output i_ld_data,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_rdata,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_rdata,
    input  o_lsu_addr, o_st_data, o_funct3, o_lsu_wren
  );
endinterface

// File: rtl/lsu_arbiter.sv
// Two-requester arbiter in front of a single LSU. One transaction at a time:
// accept in IDLE, drive the LSU in ISSUE, capture load data in CAPTURE,
// respond to the owner on the following cycle.
module lsu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic         i_clk,
  input logic         i_rst,
  lsu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_ptr;
  logic        r_owner;
  logic        r_wren;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;

  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_grant_valid;
  logic        w_grant_id;
  logic        w_ready0;
  logic        w_ready1;

  // Next-state and grant decision; ready is only ever raised in IDLE
  always_comb begin
    w_next        = r_state;
    w_grant_valid = 1'b0;
    w_grant_id    = 1'b0;
    w_ready0      = 1'b0;
    w_ready1      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_rst && (bus.i_req0_valid || bus.i_req1_valid)) begin
          w_grant_valid = 1'b1;
          if (bus.i_req0_valid && bus.i_req1_valid)
            w_grant_id = RR_EN ? r_ptr : 1'b0;
          else
            w_grant_id = bus.i_req1_valid;
          w_ready0 = ~w_grant_id;
          w_ready1 = w_grant_id;
          w_next   = ISSUE;
        end
      end
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Latch the winning request and move the round-robin pointer past it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_wren   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else if (w_grant_valid) begin
      r_ptr    <= ~w_grant_id;
      r_owner  <= w_grant_id;
      r_wren   <= w_grant_id ? bus.i_req1_wren   : bus.i_req0_wren;
      r_addr   <= w_grant_id ? bus.i_req1_addr   : bus.i_req0_addr;
      r_wdata  <= w_grant_id ? bus.i_req1_wdata  : bus.i_req0_wdata;
      r_funct3 <= w_grant_id ? bus.i_req1_funct3 : bus.i_req0_funct3;
    end
  end

  // Capture LSU data for the owner and pulse its response one cycle later
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_rsp0_valid <= (r_state == CAPTURE) && !r_owner;
      r_rsp1_valid <= (r_state == CAPTURE) &&  r_owner;
      if (r_state == CAPTURE) begin
        if (r_owner) r_rdata1 <= r_wren ? '0 : bus.i_ld_data;
        else         r_rdata0 <= r_wren ? '0 : bus.i_ld_data;
      end
    end
  end

  assign bus.o_req0_ready = w_ready0;
  assign bus.o_req1_ready = w_ready1;
  assign bus.o_rsp0_valid = r_rsp0_valid;
  assign bus.o_rsp1_valid = r_rsp1_valid;
  assign bus.o_rsp0_rdata = r_rdata0;
  assign bus.o_rsp1_rdata = r_rdata1;
  assign bus.o_lsu_addr   = r_addr;
  assign bus.o_st_data    = r_wdata;
  assign bus.o_funct3     = r_funct3;
  assign bus.o_lsu_wren   = (r_state == ISSUE) && r_wren;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: a round-robin instance carries the
// scoreboarded traffic, a fixed-priority instance checks grant order.
module tb_lsu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_arbiter_if a ();
  lsu_arbiter_if b ();

  lsu_arbiter #(.RR_EN(1'b1)) u_rr (.i_clk(clk), .i_rst(rst), .bus(a.slave));
  lsu_arbiter #(.RR_EN(1'b0)) u_fp (.i_clk(clk), .i_rst(rst), .bus(b.slave));

  typedef struct {
    bit          id;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Pop and compare any response produced by the round-robin instance
  task automatic mon();
    exp_t e;
    if (a.o_rsp0_valid === 1'b1 || a.o_rsp1_valid === 1'b1) begin
      chk("rsp_onehot", 32'(a.o_rsp0_valid & a.o_rsp1_valid), 32'd0);
      chk("rsp_expected", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rsp_id", 32'(a.o_rsp1_valid), 32'(e.id));
        chk("rsp_data", e.id ? a.o_rsp1_rdata : a.o_rsp0_rdata, e.data);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      chk("rsp_missing", cyc, sbq[0].cyc);
      void'(sbq.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic drive_a(bit id, bit v, logic [31:0] addr, logic [31:0] wd,
                         logic [2:0] f3, bit wr);
    if (!id) begin
      a.i_req0_valid = v; a.i_req0_addr = addr; a.i_req0_wdata = wd;
      a.i_req0_funct3 = f3; a.i_req0_wren = wr;
    end else begin
      a.i_req1_valid = v; a.i_req1_addr = addr; a.i_req1_wdata = wd;
      a.i_req1_funct3 = f3; a.i_req1_wren = wr;
    end
  endtask

  task automatic push(bit id, logic [31:0] data, int unsigned at);
    exp_t e;
    e.id = id; e.data = data; e.cyc = at;
    sbq.push_back(e);
  endtask

  // One isolated transaction on the round-robin instance
  task automatic txn(bit id, logic [31:0] addr, logic [31:0] wd, logic [2:0] f3,
                     bit wr, logic [31:0] ld);
    drive_a(id, 1'b1, addr, wd, f3, wr);
    #1;
    chk("accept_ready0", 32'(a.o_req0_ready), 32'(!id));
    chk("accept_ready1", 32'(a.o_req1_ready), 32'(id));
    push(id, wr ? 32'd0 : ld, cyc + 3);
    step();
    // fields scrambled after accept must not reach the LSU
    drive_a(id, 1'b0, ~addr, ~wd, ~f3, !wr);
    chk("issue_wren", 32'(a.o_lsu_wren), 32'(wr));
    chk("issue_addr", a.o_lsu_addr, addr);
    chk("issue_wdata", a.o_st_data, wd);
    chk("issue_funct3", 32'(a.o_funct3), 32'(f3));
    step();
    chk("capture_wren", 32'(a.o_lsu_wren), 32'd0);
    chk("capture_addr_hold", a.o_lsu_addr, addr);
    a.i_ld_data = ld;
    step();
    a.i_ld_data = ~ld;
  endtask

  initial begin
    int unsigned w;
    int unsigned last;
    int unsigned t0;
    bit          id;

    a.i_req0_valid = 0; a.i_req0_addr = '0; a.i_req0_wdata = '0; a.i_req0_funct3 = '0; a.i_req0_wren = 0;
    a.i_req1_valid = 0; a.i_req1_addr = '0; a.i_req1_wdata = '0; a.i_req1_funct3 = '0; a.i_req1_wren = 0;
    a.i_ld_data = '0;
    b.i_req0_valid = 0; b.i_req0_addr = '0; b.i_req0_wdata = '0; b.i_req0_funct3 = '0; b.i_req0_wren = 0;
    b.i_req1_valid = 0; b.i_req1_addr = '0; b.i_req1_wdata = '0; b.i_req1_funct3 = '0; b.i_req1_wren = 0;
    b.i_ld_data = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ready0", 32'(a.o_req0_ready), 32'd0);
    chk("rst_ready1", 32'(a.o_req1_ready), 32'd0);
    chk("rst_rsp0", 32'(a.o_rsp0_valid), 32'd0);
    chk("rst_rsp1", 32'(a.o_rsp1_valid), 32'd0);
    chk("rst_rdata0", a.o_rsp0_rdata, 32'd0);
    chk("rst_rdata1", a.o_rsp1_rdata, 32'd0);
    chk("rst_lsu_addr", a.o_lsu_addr, 32'd0);
    chk("rst_st_data", a.o_st_data, 32'd0);
    chk("rst_funct3", 32'(a.o_funct3), 32'd0);
    chk("rst_lsu_wren", 32'(a.o_lsu_wren), 32'd0);
    rst = 1'b0;

    // Req0 load, then single-cycle rsp pulse and rdata hold
    txn(1'b0, 32'h0000_0100, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF);
    step();
    chk("rsp0_pulse_end", 32'(a.o_rsp0_valid), 32'd0);
    chk("rdata0_hold", a.o_rsp0_rdata, 32'hDEAD_BEEF);

    // Req1 unaligned load (address passthrough), then store zeroes rdata1
    txn(1'b1, 32'h0000_0003, 32'h0, 3'b100, 1'b0, 32'h0000_00A5);
    txn(1'b1, 32'h0000_7000, 32'h1234_5678, 3'b010, 1'b1, 32'hCAFE_F00D);
    step();
    chk("store_idle_wren", 32'(a.o_lsu_wren), 32'd0);
    chk("rdata0_untouched", a.o_rsp0_rdata, 32'hDEAD_BEEF);
    chk("rdata1_store_zero", a.o_rsp1_rdata, 32'd0);

    // Round-robin with both requesters valid continuously
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_a(1'b0, 1'b1, 32'h10, 32'h0, 3'b010, 1'b0);
    drive_a(1'b1, 1'b1, 32'h20, 32'h0, 3'b010, 1'b0);
    a.i_ld_data = 32'h1111_2222;
    #1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!(a.o_req0_ready || a.o_req1_ready) && w < 6) begin
        step();
        w++;
      end
      chk("rr_grant_seen", 32'(a.o_req0_ready | a.o_req1_ready), 32'd1);
      chk("rr_onehot", 32'(a.o_req0_ready & a.o_req1_ready), 32'd0);
      id = a.o_req1_ready;
      chk("rr_order", 32'(id), 32'(k % 2));
      if (k > 0) chk("rr_spacing", cyc - last, 32'd3);
      last = cyc;
      push(id, 32'h1111_2222, cyc + 3);
      step();
      chk("rr_issue_addr", a.o_lsu_addr, id ? 32'h20 : 32'h10);
    end
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 3'b0, 1'b0);
    drive_a(1'b1, 1'b0, 32'h0, 32'h0, 3'b0, 1'b0);
    step();
    step();

    // Reset the cycle after a store accept aborts it
    drive_a(1'b1, 1'b1, 32'h0000_7000, 32'h1234_5678, 3'b010, 1'b1);
    #1;
    chk("abort_ready1", 32'(a.o_req1_ready), 32'd1);
    step();
    chk("abort_issue_wren", 32'(a.o_lsu_wren), 32'd1);
    rst = 1'b1;
    drive_a(1'b1, 1'b0, 32'h0, 32'h0, 3'b0, 1'b0);
    step();
    chk("abort_wren", 32'(a.o_lsu_wren), 32'd0);
    chk("abort_addr", a.o_lsu_addr, 32'd0);
    chk("abort_st_data", a.o_st_data, 32'd0);
    chk("abort_funct3", 32'(a.o_funct3), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("abort_no_rsp1", 32'(a.o_rsp1_valid), 32'd0);
    end
    chk("abort_rdata1", a.o_rsp1_rdata, 32'd0);
    txn(1'b0, 32'h0000_0044, 32'h0, 3'b000, 1'b0, 32'h0BAD_F00D);

    // Req1 arriving during req0's ISSUE waits for the next IDLE
    drive_a(1'b0, 1'b1, 32'h300, 32'h0, 3'b010, 1'b0);
    #1;
    chk("late_ready0", 32'(a.o_req0_ready), 32'd1);
    t0 = cyc;
    push(1'b0, 32'h3333_0000, cyc + 3);
    step();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 3'b0, 1'b0);
    drive_a(1'b1, 1'b1, 32'h200, 32'h0000_ABCD, 3'b001, 1'b1);
    #1;
    chk("late_wait_issue", 32'(a.o_req1_ready), 32'd0);
    step();
    chk("late_wait_capture", 32'(a.o_req1_ready), 32'd0);
    a.i_ld_data = 32'h3333_0000;
    step();
    chk("late_ready1", 32'(a.o_req1_ready), 32'd1);
    chk("late_spacing", cyc - t0, 32'd3);
    push(1'b1, 32'd0, cyc + 3);
    step();
    drive_a(1'b1, 1'b0, 32'h0, 32'h0, 3'b0, 1'b0);
    chk("late_issue_wren", 32'(a.o_lsu_wren), 32'd1);
    chk("late_issue_addr", a.o_lsu_addr, 32'h200);
    chk("late_issue_wdata", a.o_st_data, 32'h0000_ABCD);
    step();
    step();

    // Fixed priority: req0 always wins; req1 only once req0 drops
    b.i_req0_valid = 1'b1; b.i_req0_addr = 32'h40;
    b.i_req1_valid = 1'b1; b.i_req1_addr = 32'h80;
    #1;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      while (!(b.o_req0_ready || b.o_req1_ready) && w < 6) begin
        step();
        w++;
      end
      chk("fp_grant_req0", 32'(b.o_req0_ready), 32'd1);
      chk("fp_no_req1", 32'(b.o_req1_ready), 32'd0);
      if (k > 0) chk("fp_spacing", cyc - last, 32'd3);
      last = cyc;
      step();
    end
    b.i_req0_valid = 1'b0;
    w = 0;
    while (!b.o_req1_ready && w < 6) begin
      step();
      w++;
    end
    chk("fp_req1_after_drop", 32'(b.o_req1_ready), 32'd1);
    chk("fp_req1_spacing", cyc - last, 32'd3);
    step();
    b.i_req1_valid = 1'b0;
    chk("fp_issue_addr", b.o_lsu_addr, 32'h80);
    repeat (3) step();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
